dsram_resp: RTL

DSRAM_RESP -- requirements
Module: dsram_resp

---
 rtl/dsram_resp_if.sv | 23 ++
 rtl/dsram_resp.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dsram_resp_if.sv
// Initiator <-> data-SRAM responder bus: address handshake plus in-order response pulse.
interface dsram_resp_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_stall;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   modport master (
      output req, wr, size, wstrb, addr, wdata, addr_stall,
      input  addr_ok, data_ok, rdata
   );

   modport slave (
      input  req, wr, size, wstrb, addr, wdata, addr_stall,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/dsram_resp.sv
// Data SRAM responder: word-addressed store with byte-lane writes and a fixed-latency,
// in-order response FIFO. Read data is captured at acceptance, so later writes never
// leak into an earlier read's response.
module dsram_resp #(
   parameter int ADDR_W = 10,
   parameter int DELAY  = 2,
   parameter int DEPTH  = 2
) (
   input  logic        clk,
   input  logic        resetn,
   dsram_resp_if.slave bus
);
   localparam int WORDS = 1 << ADDR_W;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [3:0]       AGE_MAX  = 4'(DELAY);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   // Backing store
   logic [31:0] mem [WORDS];

   // Response FIFO state
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [DEPTH-1:0] is_wr_q, is_wr_d;
   logic [31:0]      data_q  [DEPTH];
   logic [31:0]      data_d  [DEPTH];
   logic [3:0]       age_q   [DEPTH];
   logic [3:0]       age_d   [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [ADDR_W-1:0] word_idx;
   logic [31:0]       rd_word;
   logic              push;
   logic              pop;
   logic              unused_bits;

   // Byte offset and upper address bits alias away; size is informational only.
   assign unused_bits = ^{bus.size, bus.addr[31:ADDR_W+2], bus.addr[1:0]};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign word_idx = bus.addr[ADDR_W+1:2];
   assign rd_word  = mem[word_idx];

   // Full check uses the pre-pop count: a popping head does not free a slot this cycle.
   assign bus.addr_ok = bus.req & ~bus.addr_stall & (count_q < CNT_FULL);
   assign push        = bus.req & bus.addr_ok;
   assign pop         = valid_q[rd_ptr_q] & (age_q[rd_ptr_q] == AGE_MAX);

   assign bus.data_ok = pop;
   assign bus.rdata   = (pop && !is_wr_q[rd_ptr_q]) ? data_q[rd_ptr_q] : 32'h0;

   // Byte-lane write into the store on a write handshake.
   // NOTE: the store is intentionally left out of reset so its contents survive it,
   // and so it can map onto a plain RAM macro.
   always_ff @(posedge clk) begin
      if (push && bus.wr) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.wstrb[i]) mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
         end
      end
   end

   // Next-state for the response FIFO: age, pop the head, push the new entry.
   // NOTE: every output of this block takes a default first so no latch can be inferred.
   always_comb begin
      valid_d  = valid_q;
      is_wr_d  = is_wr_q;
      data_d   = data_q;
      age_d    = age_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 4'd1;
      end

      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = ptr_inc(rd_ptr_q);
      end

      // Push slot never equals the pop slot: a push needs count < DEPTH.
      if (push) begin
         valid_d[wr_ptr_q] = 1'b1;
         is_wr_d[wr_ptr_q] = bus.wr;
         data_d[wr_ptr_q]  = bus.wr ? 32'h0 : rd_word;
         age_d[wr_ptr_q]   = 4'd1;
         wr_ptr_d          = ptr_inc(wr_ptr_q);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers with synchronous active-low reset that discards outstanding work.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q  <= '0;
         is_wr_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= 32'h0;
            age_q[i]  <= 4'd0;
         end
      end else begin
         valid_q  <= valid_d;
         is_wr_q  <= is_wr_d;
         data_q   <= data_d;
         age_q    <= age_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule
